// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: line-granular main-memory model behind the cache.
// Accepts one line read or write at a time over a valid/ready channel,
// waits LATENCY cycles, then either commits the write (one-cycle done
// pulse) or streams the line back as four 32-bit beats, word 0 first.
// Line storage survives rst; only the control path is reset.

module main_memory_ctrl #(
  parameter int DEPTH_LINES = 256,  // power of two
  parameter int LATENCY     = 4     // >= 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reqValid_MEM,
  output logic         reqReady_MEM,
  input  logic [31:0]  reqAddress_MEM,
  input  logic         reqWen_MEM,
  input  logic [127:0] reqDataIn_MEM,
  output logic         respValid_MEM,
  output logic [31:0]  respDataOut_MEM,
  output logic         respLast_MEM,
  output logic         respWriteDone_MEM
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  // Counter holds LATENCY-1 down to 0; keep at least one bit for LATENCY=1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  // Control state and captured request
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wen_q;
  logic [127:0]       line_q;
  logic [1:0]         beat_q;

  // Registered outputs
  logic               ready_q;
  logic               valid_q;
  logic [31:0]        data_q;
  logic               last_q;
  logic               done_q;

  // NOTE: the line array has no reset; a power-on initialiser zeroes it once
  // and rst must leave it alone so data persists across resets.
  logic [127:0] mem_q [DEPTH_LINES] = '{default: '0};

  // Combinational helpers
  logic         commit_d;
  logic [127:0] rd_line_d;
  logic [1:0]   next_beat_d;

  // Address bits outside the line index carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{reqAddress_MEM[31:4+IDX_W], reqAddress_MEM[3:0]};

  assign commit_d    = (state_q == S_WAIT) && (cnt_q == '0) && wen_q;
  assign rd_line_d   = mem_q[idx_q];
  assign next_beat_d = beat_q + 2'd1;

  // Commit a captured write line on the edge its latency expires.
  always_ff @(posedge clk) begin
    if (commit_d) begin
      mem_q[idx_q] <= line_q;
    end
  end

  // Request/latency/burst FSM with registered handshake and response outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and the simulation order of blocks cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Write-done is a single-cycle pulse.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (reqValid_MEM) begin
            idx_q   <= reqAddress_MEM[4 +: IDX_W];
            wen_q   <= reqWen_MEM;
            line_q  <= reqDataIn_MEM;
            cnt_q   <= CNT_W'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            if (wen_q) begin
              // Array is written by the commit block on this same edge.
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              beat_q  <= 2'd0;
              valid_q <= 1'b1;
              data_q  <= rd_line_d[31:0];
              last_q  <= 1'b0;
              state_q <= S_BURST;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BURST: begin
          if (beat_q == 2'd3) begin
            // Data is forced to zero whenever no beat is being presented.
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            beat_q <= next_beat_d;
            data_q <= rd_line_d[{next_beat_d, 5'd0} +: 32];
            last_q <= (next_beat_d == 2'd3);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reqReady_MEM      = ready_q;
  assign respValid_MEM     = valid_q;
  assign respDataOut_MEM   = data_q;
  assign respLast_MEM      = last_q;
  assign respWriteDone_MEM = done_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl (DEPTH_LINES=256, LATENCY=4).
// Expected beats / write-done pulses, each tagged with the cycle it must
// appear in, are queued at request acceptance from a reference line array
// and popped by a negedge monitor.

module tb_main_memory_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         reqValid_MEM;
  logic         reqReady_MEM;
  logic [31:0]  reqAddress_MEM;
  logic         reqWen_MEM;
  logic [127:0] reqDataIn_MEM;
  logic         respValid_MEM;
  logic [31:0]  respDataOut_MEM;
  logic         respLast_MEM;
  logic         respWriteDone_MEM;

  main_memory_ctrl #(
    .DEPTH_LINES(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .reqValid_MEM     (reqValid_MEM),
    .reqReady_MEM     (reqReady_MEM),
    .reqAddress_MEM   (reqAddress_MEM),
    .reqWen_MEM       (reqWen_MEM),
    .reqDataIn_MEM    (reqDataIn_MEM),
    .respValid_MEM    (respValid_MEM),
    .respDataOut_MEM  (respDataOut_MEM),
    .respLast_MEM     (respLast_MEM),
    .respWriteDone_MEM(respWriteDone_MEM)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    logic        last;
    int          at;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] model [DEPTH];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           e0;
  int           e_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, reqReady_MEM, 1'b1);
    check({tag, "_valid"}, respValid_MEM, 1'b0);
    check({tag, "_last"}, respLast_MEM, 1'b0);
    check({tag, "_done"}, respWriteDone_MEM, 1'b0);
    check({tag, "_data"}, respDataOut_MEM, 32'h0);
  endtask

  // Drive a request from a negedge and wait for acceptance; reqValid_MEM is
  // left high so the caller decides whether to drop it. Queues expectations.
  task automatic issue(input logic [31:0] a, input logic w, input logic [127:0] d,
                       input bit commit);
    int         n;
    logic [7:0] idx;
    n = 0;
    reqAddress_MEM = a;
    reqWen_MEM     = w;
    reqDataIn_MEM  = d;
    reqValid_MEM   = 1'b1;
    while (!reqReady_MEM && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", reqReady_MEM, 1'b1);
    @(negedge clk);
    e0  = cyc;
    idx = a[4 +: 8];
    if (w) begin
      if (commit) begin
        model[idx] = d;
        sb.push_back('{is_wr: 1'b1, data: 32'h0, last: 1'b0, at: e0 + LAT});
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        sb.push_back('{is_wr: 1'b0, data: model[idx][32*k +: 32],
                       last: (k == 3), at: e0 + LAT + k});
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  // Response monitor: output invariants every cycle, scoreboard pop on events.
  always @(negedge clk) begin
    check("valid_done_excl", respValid_MEM && respWriteDone_MEM, 1'b0);
    if (!respValid_MEM) check("data_zero_idle", respDataOut_MEM, 32'h0);
    if (respValid_MEM || respWriteDone_MEM) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {respValid_MEM, respWriteDone_MEM}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("resp_kind", respWriteDone_MEM, mon_e.is_wr);
        check("resp_cycle", cyc, mon_e.at);
        if (!mon_e.is_wr) begin
          check("beat_data", respDataOut_MEM, mon_e.data);
          check("beat_last", respLast_MEM, mon_e.last);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst            = 1'b1;
    reqValid_MEM   = 1'b0;
    reqAddress_MEM = '0;
    reqWen_MEM     = 1'b0;
    reqDataIn_MEM  = '0;

    // Reset state, then release away from any edge
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_por", reqReady_MEM, 1'b1);

    // Write then read line 0
    issue(32'h0000_0000, 1'b1, 128'h47390121_55739084_849292bb_002342ab, 1'b1);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0000, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();

    // Byte offset within a line is ignored
    issue(32'h0000_000C, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();

    // Aliasing: 0x1000 maps onto line 0; line 1 untouched
    issue(32'h0000_1000, 1'b1, {4{32'hDEADBEEF}}, 1'b1);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0000, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0010, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();

    // Back-to-back with valid held: junk writes while not ready are ignored
    issue(32'h0000_0000, 1'b0, '0, 1'b0);
    e_rd = e0;
    for (int j = 0; j < 5; j++) begin
      reqWen_MEM     = 1'b1;
      reqAddress_MEM = (j % 2 == 0) ? 32'h0000_0010 : 32'h0000_0040;
      reqDataIn_MEM  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    issue(32'h0000_0030, 1'b1, 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF, 1'b1);
    reqValid_MEM = 1'b0;
    check("b2b_accept_cycle", e0, e_rd + LAT + 5);
    drain();
    issue(32'h0000_0030, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0010, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0040, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();

    // Asynchronous reset mid-burst: outputs clear at once, burst truncated
    issue(32'h0000_0030, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    while (cyc < e0 + LAT + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", reqReady_MEM, 1'b1);
    repeat (4) @(negedge clk);

    // Reset before commit discards the write; prior contents survive
    issue(32'h0000_0020, 1'b1, {4{32'h11111111}}, 1'b1);
    reqValid_MEM = 1'b0;
    drain();
    issue(32'h0000_0020, 1'b1, {4{32'h19475820}}, 1'b0);
    reqValid_MEM = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(32'h0000_0020, 1'b0, '0, 1'b0);
    reqValid_MEM = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
